// File: rtl/multi_cycle_controller_pkg.sv
// multi_cycle_controller_pkg: shared opcode, state and select encodings for the multi-cycle controller.
package multi_cycle_controller_pkg;
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALTED
  } controller_state_t;
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } program_counter_select_t;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } writeback_select_t;
endpackage

// File: rtl/multi_cycle_controller_instruction_class_decoder.sv
// instruction_class_decoder: maps an opcode to legality, memory class and datapath selects.
module instruction_class_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       is_memory,
  output logic       is_store,
  output logic       is_branch,
  output logic       writes_rd,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [1:0] program_counter_select,
  output logic [1:0] writeback_select
);
  always_comb begin
    legal = 1'b0;
    is_memory = 1'b0;
    is_store = 1'b0;
    is_branch = 1'b0;
    writes_rd = 1'b0;
    alu_operand_a_select = 1'b0;
    alu_operand_b_select = 1'b0;
    program_counter_select = PC_PLUS4;
    writeback_select = WB_ALU;
    case (opcode_t'(opcode))
      OPC_LOAD: begin
        legal = 1'b1;
        is_memory = 1'b1;
        writes_rd = 1'b1;
        alu_operand_b_select = 1'b1;
        writeback_select = WB_MEM;
      end
      OPC_STORE: begin
        legal = 1'b1;
        is_memory = 1'b1;
        is_store = 1'b1;
        alu_operand_b_select = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1;
        is_branch = 1'b1;
        program_counter_select = PC_IMM;
      end
      OPC_JAL: begin
        legal = 1'b1;
        writes_rd = 1'b1;
        program_counter_select = PC_IMM;
        writeback_select = WB_PC4;
      end
      OPC_JALR: begin
        legal = 1'b1;
        writes_rd = 1'b1;
        alu_operand_b_select = 1'b1;
        program_counter_select = PC_ALU;
        writeback_select = WB_PC4;
      end
      OPC_OP: begin
        legal = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        writes_rd = 1'b1;
        alu_operand_b_select = 1'b1;
      end
      OPC_LUI: begin
        legal = 1'b1;
        writes_rd = 1'b1;
        writeback_select = WB_IMM;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        writes_rd = 1'b1;
        alu_operand_a_select = 1'b1;
        alu_operand_b_select = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: fetch/decode/execute/memory/writeback sequencer for a tiny RISC-V datapath.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        memory_ready,
  input  logic        branch_condition,
  output logic        memory_request,
  output logic        memory_write_enable,
  output logic        memory_address_select,
  output logic        instruction_write_enable,
  output logic        program_counter_write_enable,
  output logic [1:0]  program_counter_select,
  output logic        alu_operand_a_select,
  output logic        alu_operand_b_select,
  output logic        register_write_enable,
  output logic [1:0]  writeback_select,
  output logic        instruction_retired,
  output logic        halted
);
  controller_state_t state_q, state_d;
  logic legal, is_memory, is_store, is_branch, writes_rd, a_sel, b_sel;
  logic [1:0] pc_sel, wb_sel;
  instruction_class_decoder u_decoder (
    .opcode                 (instruction[6:0]),
    .legal                  (legal),
    .is_memory              (is_memory),
    .is_store               (is_store),
    .is_branch              (is_branch),
    .writes_rd              (writes_rd),
    .alu_operand_a_select   (a_sel),
    .alu_operand_b_select   (b_sel),
    .program_counter_select (pc_sel),
    .writeback_select       (wb_sel)
  );
  always_ff @(posedge clock) state_q <= reset ? ST_FETCH : state_d;
  // Outputs are forced low while reset is high so an in-flight access is dropped immediately.
  always_comb begin
    state_d = state_q;
    memory_request = 1'b0;
    memory_write_enable = 1'b0;
    memory_address_select = 1'b0;
    instruction_write_enable = 1'b0;
    program_counter_write_enable = 1'b0;
    program_counter_select = PC_PLUS4;
    alu_operand_a_select = 1'b0;
    alu_operand_b_select = 1'b0;
    register_write_enable = 1'b0;
    writeback_select = WB_ALU;
    instruction_retired = 1'b0;
    halted = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          memory_request = 1'b1;
          instruction_write_enable = memory_ready;
          state_d = memory_ready ? ST_DECODE : ST_FETCH;
        end
        ST_DECODE: state_d = legal ? ST_EXECUTE : ST_HALTED;
        ST_EXECUTE: begin
          alu_operand_a_select = a_sel;
          alu_operand_b_select = b_sel;
          state_d = is_memory ? ST_MEMORY : ST_WRITEBACK;
        end
        ST_MEMORY: begin
          memory_request = 1'b1;
          memory_address_select = 1'b1;
          memory_write_enable = is_store;
          state_d = memory_ready ? ST_WRITEBACK : ST_MEMORY;
        end
        ST_WRITEBACK: begin
          program_counter_write_enable = 1'b1;
          instruction_retired = 1'b1;
          program_counter_select = (is_branch && !branch_condition) ? PC_PLUS4 : pc_sel;
          register_write_enable = writes_rd && (instruction[11:7] != 5'd0);
          writeback_select = wb_sel;
          state_d = ST_FETCH;
        end
        default: halted = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: randomized instruction streams checked cycle-by-cycle against an expected-trace model.
module tb_multi_cycle_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instruction = '0;
  logic memory_ready = 1'b0;
  logic branch_condition = 1'b0;
  logic memory_request, memory_write_enable, memory_address_select, instruction_write_enable;
  logic program_counter_write_enable, alu_operand_a_select, alu_operand_b_select;
  logic register_write_enable, instruction_retired, halted;
  logic [1:0] program_counter_select, writeback_select;
  logic [13:0] got;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  multi_cycle_controller dut (
    .clock                        (clock),
    .reset                        (reset),
    .instruction                  (instruction),
    .memory_ready                 (memory_ready),
    .branch_condition             (branch_condition),
    .memory_request               (memory_request),
    .memory_write_enable          (memory_write_enable),
    .memory_address_select        (memory_address_select),
    .instruction_write_enable     (instruction_write_enable),
    .program_counter_write_enable (program_counter_write_enable),
    .program_counter_select       (program_counter_select),
    .alu_operand_a_select         (alu_operand_a_select),
    .alu_operand_b_select         (alu_operand_b_select),
    .register_write_enable        (register_write_enable),
    .writeback_select             (writeback_select),
    .instruction_retired          (instruction_retired),
    .halted                       (halted)
  );
  assign got = {memory_request, memory_write_enable, memory_address_select, instruction_write_enable,
                program_counter_write_enable, program_counter_select, alu_operand_a_select,
                alu_operand_b_select, register_write_enable, writeback_select, instruction_retired, halted};
  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask
  typedef struct packed {
    bit legal, mem, st, br, jal, jalr, wr, a, b;
    bit [1:0] wb;
  } attr_t;
  // Instruction classes straight from the opcode table.
  function automatic attr_t classify(input logic [6:0] op);
    attr_t r = '0;
    case (op)
      7'h03: begin r.legal = 1; r.mem = 1; r.wr = 1; r.b = 1; r.wb = 2'd1; end
      7'h23: begin r.legal = 1; r.mem = 1; r.st = 1; r.b = 1; end
      7'h63: begin r.legal = 1; r.br = 1; end
      7'h6f: begin r.legal = 1; r.jal = 1; r.wr = 1; r.wb = 2'd2; end
      7'h67: begin r.legal = 1; r.jalr = 1; r.wr = 1; r.b = 1; r.wb = 2'd2; end
      7'h33: begin r.legal = 1; r.wr = 1; end
      7'h13: begin r.legal = 1; r.wr = 1; r.b = 1; end
      7'h37: begin r.legal = 1; r.wr = 1; r.wb = 2'd3; end
      7'h17: begin r.legal = 1; r.wr = 1; r.a = 1; r.b = 1; end
      default: ;
    endcase
    return r;
  endfunction
  function automatic logic [13:0] ov(input bit req, mwe, mas, irw, pcw, input bit [1:0] pcs,
                                     input bit a, b, rfw, input bit [1:0] wbs, input bit ret, hlt);
    return {req, mwe, mas, irw, pcw, pcs, a, b, rfw, wbs, ret, hlt};
  endfunction
  typedef struct packed {
    logic [13:0] e;
    logic [1:0] rdy;
    logic in_wb;
  } step_t;
  function automatic step_t stp(input logic [13:0] e, input logic [1:0] rdy, input logic in_wb);
    step_t s;
    s.e = e;
    s.rdy = rdy;
    s.in_wb = in_wb;
    return s;
  endfunction
  // rdy: 0/1 drive that value, 2 = random (memory_ready must be ignored there)
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit br,
                           input int cut, input int hold);
    step_t q[$];
    attr_t c = classify(ins[6:0]);
    bit [1:0] pcs;
    int n;
    repeat (fw) q.push_back(stp(ov(1,0,0,0,0,0,0,0,0,0,0,0), 2'd0, 1'b0));
    q.push_back(stp(ov(1,0,0,1,0,0,0,0,0,0,0,0), 2'd1, 1'b0));
    q.push_back(stp(14'd0, 2'd2, 1'b0));
    if (!c.legal) begin
      repeat (hold) q.push_back(stp(ov(0,0,0,0,0,0,0,0,0,0,0,1), 2'd2, 1'b0));
    end else begin
      q.push_back(stp(ov(0,0,0,0,0,0,c.a,c.b,0,0,0,0), 2'd2, 1'b0));
      if (c.mem) begin
        repeat (mw) q.push_back(stp(ov(1,c.st,1,0,0,0,0,0,0,0,0,0), 2'd0, 1'b0));
        q.push_back(stp(ov(1,c.st,1,0,0,0,0,0,0,0,0,0), 2'd1, 1'b0));
      end
      pcs = c.jal ? 2'd1 : c.jalr ? 2'd2 : (c.br && br) ? 2'd1 : 2'd0;
      q.push_back(stp(ov(0,0,0,0,1,pcs,0,0,c.wr && ins[11:7] != 0,c.wb,1,0), 2'd2, 1'b1));
    end
    n = (cut > 0 && cut < q.size()) ? cut : q.size();
    instruction = ins;
    for (int i = 0; i < n; i++) begin
      memory_ready = (q[i].rdy == 2'd2) ? 1'($urandom) : q[i].rdy[0];
      branch_condition = q[i].in_wb ? br : 1'($urandom);
      @(negedge clock);
      check($sformatf("ins %h cycle %0d outputs", ins, i + 1), 32'(got), 32'(q[i].e));
      @(posedge clock);
      #1;
    end
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      memory_ready = 1'($urandom);
      branch_condition = 1'($urandom);
      instruction = $urandom;
      @(negedge clock);
      check("reset outputs", 32'(got), 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end
  initial begin
    logic [6:0] ops [12];
    logic [31:0] r;
    logic [6:0] op;
    attr_t c;
    int fw, mw, cut, hold;
    ops = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h0f, 7'h73, 7'h00};
    do_reset(2);
    run_instr(32'h00500093, 0, 0, 1'b0, 0, 0);
    run_instr(32'h0000A103, 0, 2, 1'b0, 0, 0);
    run_instr(32'h0020A223, 0, 0, 1'b0, 0, 0);
    run_instr(32'h00000463, 0, 0, 1'b1, 0, 0);
    run_instr(32'h00000463, 0, 0, 1'b0, 0, 0);
    run_instr(32'h00100013, 1, 0, 1'b0, 0, 0);
    run_instr(32'h00000000, 0, 0, 1'b0, 0, 6);
    do_reset(1);
    run_instr(32'h0020A223, 0, 3, 1'b0, 4, 0);
    do_reset(1);
    run_instr(32'h00500093, 0, 0, 1'b0, 0, 0);
    for (int k = 0; k < 250; k++) begin
      r = $urandom;
      op = ($urandom_range(0, 15) == 0) ? r[6:0] : ops[$urandom_range(0, 11)];
      c = classify(op);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 9) : 0;
      hold = $urandom_range(1, 4);
      run_instr({r[31:7], op}, fw, mw, 1'($urandom), cut, hold);
      if (cut != 0 || !c.legal) do_reset($urandom_range(1, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

- Sequences the tiny RISC-V datapath (PC, memory port, instruction register, immediate generator, ALU, register file) through a multi-cycle fetch/decode/execute/memory/writeback flow, one instruction at a time.
- Drives the Moore-style select and enable signals for each phase.
- Holds memory requests until the shared memory port acknowledges them.
- Traps into a halted state on any unsupported opcode.

## Interface
Parameters: none.

Reset is synchronous and active-high on `reset`; `clock` is the single clock.

- clock  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high
- instruction  in  32  instruction register contents
- memory_ready  in  1  memory completes the pending access this cycle
- branch_condition  in  1  comparator result for the current branch funct3
- memory_request  out  1  access request, held until memory_ready
- memory_write_enable  out  1  pending access is a store
- memory_address_select  out  1  0 = PC, 1 = ALU result
- instruction_write_enable  out  1  load instruction register
- program_counter_write_enable  out  1  update PC
- program_counter_select  out  2  0 = PC+4, 1 = PC+immediate, 2 = ALU result with bit 0 cleared
- alu_operand_a_select  out  1  0 = rs1, 1 = PC
- alu_operand_b_select  out  1  0 = rs2, 1 = immediate
- register_write_enable  out  1  write rd
- writeback_select  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate
- instruction_retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  illegal-opcode trap; sticky until reset

## Operation
States: Fetch, Decode, Execute, Memory, Writeback, Halted.

- **Fetch**
  - Outputs: memory_request=1, memory_address_select=0.
  - Waits for memory_ready.
  - On memory_ready: instruction_write_enable=1 for that cycle, then go to Decode.
- **Decode**
  - Classifies opcode from instruction[6:0].
  - Legal opcodes: Load, Store, Branch, JAL, JALR, OP, OP-IMM, LUI, AUIPC. Any legal opcode goes to Execute.
  - Everything else, including FENCE and SYSTEM, goes to Halted.
- **Execute** (1 cycle)
  - Operand selects:
    - OP: a=rs1, b=rs2.
    - OP-IMM, Load, Store, JALR: a=rs1, b=immediate.
    - AUIPC: a=PC, b=immediate.
    - Branch: a=rs1, b=rs2.
  - Load and Store go to Memory; all others go to Writeback.
- **Memory**
  - Outputs: memory_request=1, memory_address_select=1, memory_write_enable=1 for Store only.
  - Held until memory_ready, then go to Writeback.
- **Writeback** (1 cycle)
  - Always: program_counter_write_enable=1, instruction_retired=1, then go to Fetch.
  - PC select:
    - JAL: 1.
    - JALR: 2.
    - Branch: 1 if branch_condition, else 0.
    - All others: 0.
  - register_write_enable=1 for OP, OP-IMM, Load, LUI, AUIPC, JAL, JALR, and only when rd (instruction[11:7]) ≠ 0.
  - writeback_select:
    - 1 for Load.
    - 2 for JAL/JALR.
    - 3 for LUI.
    - 0 otherwise.
- **Halted**: all outputs 0 except halted=1. Exit only via reset.
- Outputs not listed for a state are 0; unused selects are 0.
- memory_ready is ignored whenever memory_request=0.

## Timing
- **During reset**
  - While reset is high, every output is 0, including memory_request, instruction_retired and halted.
  - The state register loads Fetch at the edge.
- **After reset**: the first cycle after reset deasserts is Fetch with memory_request=1.
- **Reset mid-operation**
  - Applies in any state, including a Memory wait or Halted.
  - Outputs drop the same cycle; the access is abandoned with no write.
- **Instruction latency**, with zero-wait memory (memory_ready high in the first request cycle):
  - 4 cycles (F,D,E,W) for non-memory instructions.
  - 5 cycles (F,D,E,M,W) for Load/Store.
  - Each memory wait cycle adds 1.
- **Request stability**: memory_request, memory_write_enable and memory_address_select stay stable from the first request cycle through the memory_ready cycle inclusive.
- **Branch sampling**: branch_condition is sampled only in Writeback.
- **Retire count**: instruction_retired pulses exactly once per instruction, coincident with program_counter_write_enable.

## Structure
- The shared package gets:
  - controller_state_t (6-value enum).
  - program_counter_select_t and writeback_select_t enums, with the encodings above.
  - These sit alongside the existing opcode_t.
- One combinational sub-module, instruction_class_decoder:
  - Input: opcode.
  - Outputs: legal, is_memory, is_store, writes_rd, plus operand, PC and writeback selects.
  - The FSM registers only the state; outputs are decoded from state plus the class outputs.

## Test plan
- ADDI x1,x0,5 (0x00500093), memory_ready always 1:
  - memory_request high cycle 1 after reset.
  - alu_operand_b_select=1 in Execute.
  - Cycle 4: register_write_enable=1, writeback_select=0, program_counter_select=0, instruction_retired=1.
  - Fetch resumes cycle 5.
- LW x2,0(x1) (0x0000A103), memory_ready delayed 2 cycles in Memory:
  - memory_address_select=1 held 3 cycles with memory_write_enable=0.
  - Writeback has writeback_select=1.
  - Total 7 cycles.
- SW x2,4(x1) (0x0020A223):
  - memory_write_enable=1 in Memory.
  - register_write_enable=0 in Writeback.
  - program_counter_write_enable=1.
- BEQ x0,x0,8 (0x00000463):
  - With branch_condition=1: program_counter_select=1.
  - Repeated with 0: select=0.
  - Both cases: register_write_enable=0.
- Illegal and x0 destination:
  - 0x00000000 fetched: halted=1 from cycle 3 onward, no memory_request, no retire until reset.
  - ADDI x0,x0,1 (0x00100013): retires with register_write_enable=0.
- Reset in Memory wait of a store:
  - Outputs 0 in the reset cycle.
  - No memory_write_enable afterwards.
  - memory_request reasserts with memory_address_select=0 one cycle after reset deasserts.
